register_file: RTL and testbench

- Architectural register file with rename tags. Sits directly downstream of the reorder buffer.
- Takes the commit write (set_reg_id/set_val/set_reg_on_rob_id) and the issue-time dependency mark (set_dep_reg_id/set_dep_rob_id) from the reorder buffer.
- Answers two combinational source-operand queries from the decoder: value, or the ROB id that will produce it.
- Flush (clear) drops all pending dependencies; committed values are kept.

---
 rtl/register_file.sv | 114 +++++++++++
 tb/tb_register_file.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// Architectural register file with rename tags: commit writes, issue-time
// dependency marks, flush, and two zero-latency source-operand queries.
module register_file #(
    parameter int ROB_WIDTH_BIT = 4
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     clear,
    input  logic [4:0]               set_reg_id,
    input  logic [31:0]              set_val,
    input  logic [ROB_WIDTH_BIT-1:0] set_reg_on_rob_id,
    input  logic [4:0]               set_dep_reg_id,
    input  logic [ROB_WIDTH_BIT-1:0] set_dep_rob_id,
    input  logic [4:0]               rs1_id,
    output logic [31:0]              rs1_val,
    output logic                     rs1_has_dep,
    output logic [ROB_WIDTH_BIT-1:0] rs1_dep_rob_id,
    input  logic [4:0]               rs2_id,
    output logic [31:0]              rs2_val,
    output logic                     rs2_has_dep,
    output logic [ROB_WIDTH_BIT-1:0] rs2_dep_rob_id
);

    localparam int QW = 32 + 1 + ROB_WIDTH_BIT;

    logic [31:0]              val_q    [1:31];
    logic [ROB_WIDTH_BIT-1:0] tag_q    [1:31];
    logic [ROB_WIDTH_BIT-1:0] tag_next [1:31];
    logic [31:1]              busy_q;
    logic [31:1]              busy_next;
    logic [31:0]              pending;
    logic [31:0]              pending_next;
    logic                     commit_en;
    logic                     dep_en;
    logic [QW-1:0]            q1;
    logic [QW-1:0]            q2;

    assign commit_en = rdy_in && !clear && (set_reg_id != 5'd0);
    assign dep_en    = rdy_in && !clear && (set_dep_reg_id != 5'd0);

    always_comb begin
        busy_next    = busy_q;
        pending_next = '0;
        for (int i = 1; i < 32; i++) begin
            tag_next[i] = tag_q[i];
            if (clear) begin
                busy_next[i] = 1'b0;
                tag_next[i]  = '0;
            end else begin
                if (commit_en && set_reg_id == 5'(i) && busy_q[i]
                    && tag_q[i] == set_reg_on_rob_id)
                    busy_next[i] = 1'b0;
                // A same-cycle rename of the committing register keeps it busy.
                if (dep_en && set_dep_reg_id == 5'(i)) begin
                    busy_next[i] = 1'b1;
                    tag_next[i]  = set_dep_rob_id;
                end
            end
            pending_next = pending_next + 32'(busy_next[i]);
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            busy_q  <= '0;
            pending <= '0;
            for (int i = 1; i < 32; i++) begin
                val_q[i] <= '0;
                tag_q[i] <= '0;
            end
        end else if (rdy_in) begin
            busy_q  <= busy_next;
            pending <= pending_next;
            for (int i = 1; i < 32; i++) begin
                tag_q[i] <= tag_next[i];
                if (commit_en && set_reg_id == 5'(i))
                    val_q[i] <= set_val;
            end
        end
    end

    // Same-cycle commit of the current owner is forwarded to the decoder.
    function automatic logic [QW-1:0] query(input logic [4:0] id);
        logic [31:0]              v;
        logic                     h;
        logic [ROB_WIDTH_BIT-1:0] t;
        v = '0;
        h = 1'b0;
        t = '0;
        if (id != 5'd0) begin
            if (busy_q[id] && commit_en && set_reg_id == id
                && set_reg_on_rob_id == tag_q[id]) begin
                v = set_val;
            end else begin
                v = val_q[id];
                if (busy_q[id]) begin
                    h = 1'b1;
                    t = tag_q[id];
                end
            end
        end
        return {v, h, t};
    endfunction

    always_comb begin
        q1 = query(rs1_id);
        q2 = query(rs2_id);
    end

    assign {rs1_val, rs1_has_dep, rs1_dep_rob_id} = q1;
    assign {rs2_val, rs2_has_dep, rs2_dep_rob_id} = q2;

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: a reference model predicts each cycle's
// query responses and busy count; a negedge monitor compares them.
module tb_register_file;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, clear;
    logic [4:0]  set_reg_id, set_dep_reg_id, rs1_id, rs2_id;
    logic [31:0] set_val, rs1_val, rs2_val;
    logic [3:0]  set_reg_on_rob_id, set_dep_rob_id, rs1_dep_rob_id, rs2_dep_rob_id;
    logic        rs1_has_dep, rs2_has_dep;

    always #5 clk_in = ~clk_in;

    register_file #(.ROB_WIDTH_BIT(4)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
        .set_reg_id(set_reg_id), .set_val(set_val), .set_reg_on_rob_id(set_reg_on_rob_id),
        .set_dep_reg_id(set_dep_reg_id), .set_dep_rob_id(set_dep_rob_id),
        .rs1_id(rs1_id), .rs1_val(rs1_val), .rs1_has_dep(rs1_has_dep),
        .rs1_dep_rob_id(rs1_dep_rob_id),
        .rs2_id(rs2_id), .rs2_val(rs2_val), .rs2_has_dep(rs2_has_dep),
        .rs2_dep_rob_id(rs2_dep_rob_id)
    );

    typedef struct {
        logic [31:0] v1; logic h1; logic [3:0] t1;
        logic [31:0] v2; logic h2; logic [3:0] t2;
        logic [31:0] pend;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model: architectural state as plain arrays.
    logic [31:0] m_val  [32];
    bit          m_busy [32];
    logic [3:0]  m_tag  [32];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    always @(negedge clk_in) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("rs1_val", rs1_val, e.v1);
            check("rs1_has_dep", 32'(rs1_has_dep), 32'(e.h1));
            check("rs1_dep_rob_id", 32'(rs1_dep_rob_id), 32'(e.t1));
            check("rs2_val", rs2_val, e.v2);
            check("rs2_has_dep", 32'(rs2_has_dep), 32'(e.h2));
            check("rs2_dep_rob_id", 32'(rs2_dep_rob_id), 32'(e.t2));
            check("pending", dut.pending, e.pend);
        end
    end

    function automatic void predict(input logic [4:0] id, output logic [31:0] v,
                                    output logic h, output logic [3:0] t);
        v = 0; h = 0; t = 0;
        if (id != 0) begin
            if (m_busy[id] && rdy_in && !clear && set_reg_id == id
                && set_reg_on_rob_id == m_tag[id]) begin
                v = set_val;
            end else begin
                v = m_val[id];
                if (m_busy[id]) begin h = 1; t = m_tag[id]; end
            end
        end
    endfunction

    function automatic logic [31:0] busy_count();
        logic [31:0] c = 0;
        for (int i = 1; i < 32; i++) c += 32'(m_busy[i]);
        return c;
    endfunction

    function automatic void model_update();
        if (rst_in) begin
            for (int i = 0; i < 32; i++) begin m_val[i] = 0; m_busy[i] = 0; m_tag[i] = 0; end
        end else if (rdy_in) begin
            if (clear) begin
                for (int i = 0; i < 32; i++) begin m_busy[i] = 0; m_tag[i] = 0; end
            end else begin
                if (set_reg_id != 0) begin
                    m_val[set_reg_id] = set_val;
                    if (m_busy[set_reg_id] && m_tag[set_reg_id] == set_reg_on_rob_id)
                        m_busy[set_reg_id] = 0;
                end
                if (set_dep_reg_id != 0) begin
                    m_busy[set_dep_reg_id] = 1;
                    m_tag[set_dep_reg_id]  = set_dep_rob_id;
                end
            end
        end
    endfunction

    // One clock cycle: drive, predict the query, let the edge happen, advance model.
    task automatic step(input bit r, input bit rdy, input bit clr,
                        input logic [4:0] sr, input logic [31:0] sv, input logic [3:0] srob,
                        input logic [4:0] dr, input logic [3:0] drob,
                        input logic [4:0] a, input logic [4:0] b, input bit chk);
        exp_t e;
        rst_in = r; rdy_in = rdy; clear = clr;
        set_reg_id = sr; set_val = sv; set_reg_on_rob_id = srob;
        set_dep_reg_id = dr; set_dep_rob_id = drob;
        rs1_id = a; rs2_id = b;
        if (chk) begin
            predict(a, e.v1, e.h1, e.t1);
            predict(b, e.v2, e.h2, e.t2);
            e.pend = busy_count();
            exp_q.push_back(e);
        end
        @(posedge clk_in);
        model_update();
        #1;
    endtask

    task automatic idle(input logic [4:0] a, input logic [4:0] b);
        step(0, 1, 0, 0, 0, 0, 0, 0, a, b, 1);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin m_val[i] = 0; m_busy[i] = 0; m_tag[i] = 0; end
        #1;
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 1, 3, 32'hdead, 1, 4, 2, 0, 0, 0);
        idle(5, 0);

        // Mark, bypassed commit, busy cleared afterwards.
        step(0, 1, 0, 0, 0, 0, 3, 2, 3, 0, 1);
        idle(3, 3);
        step(0, 1, 0, 3, 32'h1234, 2, 0, 0, 3, 0, 1);
        idle(3, 0);

        // Stale commit under a younger rename.
        step(0, 1, 0, 0, 0, 0, 4, 1, 0, 0, 1);
        step(0, 1, 0, 0, 0, 0, 4, 5, 4, 0, 1);
        step(0, 1, 0, 4, 32'haa, 1, 0, 0, 4, 0, 1);
        idle(4, 4);

        // Commit and re-rename of the same register in one cycle.
        step(0, 1, 0, 0, 0, 0, 7, 3, 0, 0, 1);
        step(0, 1, 0, 7, 32'h55, 3, 7, 6, 7, 0, 1);
        idle(7, 0);

        // Rename everything, then flush alongside a commit and a mark.
        for (int i = 1; i < 32; i++) step(0, 1, 0, 0, 0, 0, 5'(i), 4'(i), 5'(i), 2, 1);
        step(0, 1, 1, 2, 32'h99, 2, 9, 7, 2, 9, 1);
        idle(2, 9);
        idle(31, 1);

        // Frozen cycle and x0 writes.
        step(0, 1, 0, 0, 0, 0, 8, 4, 0, 0, 1);
        step(0, 0, 0, 8, 32'h77, 4, 10, 3, 8, 10, 1);
        idle(8, 10);
        step(0, 1, 0, 0, 32'hffff_ffff, 0, 0, 9, 0, 0, 1);
        idle(0, 8);

        // Randomized traffic over a small register window to force collisions.
        for (int n = 0; n < 3000; n++) begin
            logic [4:0]  sr, dr;
            logic [3:0]  srob;
            bit          rr, rdy, clr;
            sr   = 5'($urandom_range(0, 7));
            dr   = 5'($urandom_range(0, 7));
            srob = ($urandom_range(0, 2) != 0) ? m_tag[sr] : 4'($urandom);
            rr   = ($urandom_range(0, 499) == 0);
            rdy  = ($urandom_range(0, 9) != 0);
            clr  = ($urandom_range(0, 39) == 0);
            step(rr, rdy, clr, sr, $urandom, srob, dr, 4'($urandom),
                 5'($urandom_range(0, 8)), 5'($urandom), 1);
        end

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk_in);
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
